// File: rtl/dmem_pkg.sv
// Shared types and sizes for the block data memory: FSM states, block/address widths.
package dmem_pkg;
    localparam int BLOCK_W    = 32;
    localparam int BADDR_W    = 6;
    localparam int DMEM_DEPTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_e;
endpackage

// File: rtl/dmem_array.sv
// Single-port block storage: synchronous write, synchronous read into an enabled output register.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               we_i,
    input  logic               re_i,
    input  logic [BADDR_W-1:0] addr_i,
    input  logic [BLOCK_W-1:0] wdata_i,
    output logic [BLOCK_W-1:0] rdata_o
);
    // Contents are never reset; only the read register is.
    logic [BLOCK_W-1:0] mem_q [DEPTH] = '{default: '0};
    logic [BLOCK_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/block_data_mem.sv
// Block-granular data memory behind the data cache: fixed-latency access via an
// IDLE/BUSY/DONE handshake on busywait, with request fields latched at the start edge.
module block_data_mem
    import dmem_pkg::*;
#(
    parameter int ACCESS_CYCLES = 5,
    parameter int DEPTH         = DMEM_DEPTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               read,
    input  logic               write,
    input  logic [BADDR_W-1:0] address,
    input  logic [BLOCK_W-1:0] writedata,
    output logic [BLOCK_W-1:0] readdata,
    output logic               busywait
);
    dmem_state_e        state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [BADDR_W-1:0] addr_q, addr_d;
    logic [BLOCK_W-1:0] wdata_q, wdata_d;
    logic               wr_q, wr_d;
    logic               acc_en;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        busywait = 1'b0;
        acc_en   = 1'b0;
        case (state_q)
            IDLE: begin
                busywait = read | write;
                if (read | write) begin
                    state_d = BUSY;
                    cnt_d   = 8'(ACCESS_CYCLES - 1);
                    addr_d  = address;
                    wdata_d = writedata;
                    wr_d    = write;  // write wins over a simultaneous read
                end
            end
            BUSY: begin
                busywait = 1'b1;
                if (cnt_q == 8'd0) begin
                    acc_en  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
        end
    end

    // Gate the write with reset so an aborted write-back never lands in storage.
    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk_i   (clock),
        .rst_i   (reset),
        .we_i    (acc_en & wr_q & ~reset),
        .re_i    (acc_en & ~wr_q),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (readdata)
    );
endmodule

// File: tb/tb_block_data_mem.sv
// Scoreboarded bench for block_data_mem: default-latency instance plus an ACCESS_CYCLES=1 instance.
module tb_block_data_mem;
    localparam int ACC = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        read, write;
    logic [5:0]  address;
    logic [31:0] writedata, readdata;
    logic        busywait;
    logic        read1, write1;
    logic [5:0]  address1;
    logic [31:0] writedata1, readdata1;
    logic        busywait1;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_m [64];
    logic [31:0] rd_m;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    block_data_mem #(.ACCESS_CYCLES(ACC)) u_dut (
        .clock(clk), .reset(reset), .read(read), .write(write), .address(address),
        .writedata(writedata), .readdata(readdata), .busywait(busywait)
    );

    block_data_mem #(.ACCESS_CYCLES(1)) u_dut1 (
        .clock(clk), .reset(reset), .read(read1), .write(write1), .address(address1),
        .writedata(writedata1), .readdata(readdata1), .busywait(busywait1)
    );

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // One full access on the default instance; scramble perturbs inputs during BUSY.
    task automatic access(input logic r, input logic w, input logic [5:0] a,
                          input logic [31:0] d, input bit scramble);
        int edges;
        @(negedge clk);
        read = r; write = w; address = a; writedata = d;
        if (w) mem_m[a] = d;
        else if (r) exp_q.push_back(mem_m[a]);
        #1;
        checks++;
        if (busywait !== 1'b1) begin
            errors++;
            $display("FAIL busy_same_cycle addr=%h got %b exp 1", a, busywait);
        end
        edges = 0;
        do begin
            @(negedge clk);
            edges++;
            if (scramble && edges == 1) begin
                address   = 6'h3F;
                writedata = $urandom;
            end
        end while (busywait === 1'b1 && edges < 50);
        read = 1'b0; write = 1'b0;
        checks++;
        if (edges != ACC + 1) begin
            errors++;
            $display("FAIL latency addr=%h got %0d edges exp %0d", a, edges, ACC + 1);
        end
        if (r && !w && exp_q.size() > 0) rd_m = exp_q.pop_front();
        checks++;
        if (readdata !== rd_m) begin
            errors++;
            $display("FAIL readdata addr=%h got %h exp %h", a, readdata, rd_m);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (busywait !== 1'b0 || readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got bw=%b rd=%h exp bw=0 rd=0", busywait, readdata);
        end
        checks++;
        if (busywait1 !== 1'b0 || readdata1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_state1 got bw=%b rd=%h exp bw=0 rd=0", busywait1, readdata1);
        end
    endtask

    task automatic test_read();
        access(1'b0, 1'b1, 6'h05, 32'hDEADBEEF, 1'b0);
        access(1'b1, 1'b0, 6'h05, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        access(1'b0, 1'b1, 6'h2A, 32'h11223344, 1'b0);
        access(1'b1, 1'b0, 6'h2A, 32'h0, 1'b0);
    endtask

    task automatic test_boundary();
        access(1'b0, 1'b1, 6'h3F, 32'h3F3F0001, 1'b0);
        access(1'b0, 1'b1, 6'h00, 32'h00000A0A, 1'b0);
        access(1'b1, 1'b0, 6'h3F, 32'h0, 1'b0);
        access(1'b1, 1'b0, 6'h00, 32'h0, 1'b0);
    endtask

    task automatic test_mid_busy();
        access(1'b0, 1'b1, 6'h01, 32'h12345678, 1'b0);
        access(1'b1, 1'b0, 6'h01, 32'h0, 1'b1);
        access(1'b1, 1'b0, 6'h3F, 32'h0, 1'b0);
    endtask

    task automatic test_simultaneous();
        access(1'b1, 1'b1, 6'h10, 32'hA5A5A5A5, 1'b0);
        access(1'b1, 1'b0, 6'h10, 32'h0, 1'b0);
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        write = 1'b1; address = 6'h07; writedata = 32'hCAFEF00D;
        repeat (4) @(negedge clk);
        checks++;
        if (busywait !== 1'b1) begin
            errors++;
            $display("FAIL abort_still_busy got %b exp 1", busywait);
        end
        reset = 1'b1; write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        rd_m = 32'h0;
        checks++;
        if (busywait !== 1'b0 || readdata !== 32'h0) begin
            errors++;
            $display("FAIL abort_state got bw=%b rd=%h exp bw=0 rd=0", busywait, readdata);
        end
        access(1'b1, 1'b0, 6'h07, 32'h0, 1'b0);
    endtask

    task automatic test_held_done();
        logic [5:0] pat;
        int         n;
        @(negedge clk);
        write1 = 1'b1; address1 = 6'h03; writedata1 = 32'h600DF00D;
        n = 0;
        do begin @(negedge clk); n++; end while (busywait1 === 1'b1 && n < 20);
        write1 = 1'b0;
        @(negedge clk);
        read1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            pat[5-i] = busywait1;
            @(negedge clk);
        end
        read1 = 1'b0;
        checks++;
        if (pat !== 6'b110110) begin
            errors++;
            $display("FAIL held_done_pattern got %b exp 110110", pat);
        end
        checks++;
        if (readdata1 !== 32'h600DF00D) begin
            errors++;
            $display("FAIL held_done_data got %h exp 600df00d", readdata1);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem_m[i] = 32'h0;
        rd_m = 32'h0;
        reset = 1'b1;
        read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        read1 = 1'b0; write1 = 1'b0; address1 = '0; writedata1 = '0;
        test_reset();
        test_read();
        test_back_to_back();
        test_boundary();
        test_mid_busy();
        test_simultaneous();
        test_reset_abort();
        test_held_done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
